// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache_ctrl slice.
// Contents:
//   - default geometry (line count, index width, address/data widths)
//   - controller state encoding
//   - lowest-set-bit priority encoder used to pick the hit line
package dcache_pkg;

  localparam int unsigned DEF_LINES    = 4;
  localparam int unsigned DEF_LINEIDX  = 2;
  localparam int unsigned DEF_ADDRBITS = 32;
  localparam int unsigned DEF_DATABITS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    FILL   = 2'b10,
    RESP   = 2'b11
  } state_e;

  // Index of the lowest set bit of v (0 when v is all zero).
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        idx   = i[2:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dcache_victim.sv
// Replacement policy for dcache_ctrl.
// Macro DCACHE_CTRL_PLRU_EN:
//   defined   - tree pseudo-LRU (heap-indexed nodes 1..LINES-1)
//   undefined - round-robin pointer advanced on fill completion
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   touch       - a line was just used (hit or fill completion, as the top decides)
//   touch_idx   - index of the line that was used
//   victim_idx  - line to replace on the next all-miss
module dcache_victim
  import dcache_pkg::*;
#(
  parameter int unsigned LINES   = DEF_LINES,
  parameter int unsigned LINEIDX = DEF_LINEIDX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch,
  input  logic [LINEIDX-1:0] touch_idx,
  output logic [LINEIDX-1:0] victim_idx
);

`ifdef DCACHE_CTRL_PLRU_EN
  // Node n has children 2n and 2n+1; bit 0 is unused and held at 0.
  logic [LINES-1:0] plru_q, plru_d;

  always_comb begin : walk
    logic [LINEIDX:0] node;
    node    = '0;
    node[0] = 1'b1;
    for (int unsigned l = 0; l < LINEIDX; l++) begin
      node = {node[LINEIDX-1:0], plru_q[node[LINEIDX-1:0]]};
    end
    // Leaf numbers run LINES..2*LINES-1, so dropping the top bit gives the line.
    victim_idx = node[LINEIDX-1:0];
  end

  always_comb begin : update
    logic [LINEIDX:0] node;
    plru_d = plru_q;
    node   = {1'b1, touch_idx};
    if (touch) begin
      for (int unsigned l = 0; l < LINEIDX; l++) begin
        // Point the parent at the sibling subtree of the touched path.
        plru_d[node[LINEIDX:1]] = ~node[0];
        node = node >> 1;
      end
    end
    plru_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) plru_q <= '0;
    else       plru_q <= plru_d;
  end
`else
  logic [LINEIDX-1:0] ptr_q, ptr_d;

  // Only fill completions touch in this build, and the filled line is
  // always the current pointer, so touch_idx+1 is the next slot.
  always_comb begin
    ptr_d = ptr_q;
    if (touch) ptr_d = touch_idx + LINEIDX'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign victim_idx = ptr_q;
`endif

endmodule

// File: rtl/dcache_ctrl.sv
// Sequencer for LINES dcache_line instances forming a small fully-associative
// data cache. Waits one cycle for the lines' registered verdicts, returns hit
// data, or on an all-miss commands a victim line to fill and lends it the
// single memory-controller port until it reports valid.
// Macro DCACHE_CTRL_PLRU_EN selects pseudo-LRU replacement (default round-robin).
// Ports:
//   clk, reset                          - clock, asynchronous active-high reset
//   cpu_rdreq/cpu_wrreq                 - CPU request, held until cpu_ready
//   cpu_dataout, cpu_ready              - read data and one-cycle completion pulse
//   multihit                            - sticky flag: >1 line hit in one cycle
//   line_fill                           - one-hot fill command pulse
//   line_valid/line_miss/line_out       - per-line verdicts and read data
//   line_mem_addr/rdreq/wrreq           - per-line memory requests
//   line_mem_valid                      - mem_valid routed to the owning line
//   mem_addr/mem_rdreq/mem_wrreq        - memory-controller request port
//   mem_valid                           - memory data valid
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES    = DEF_LINES,
  parameter int unsigned LINEIDX  = DEF_LINEIDX,
  parameter int unsigned ADDRBITS = DEF_ADDRBITS,
  parameter int unsigned DATABITS = DEF_DATABITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_rdreq,
  input  logic                      cpu_wrreq,
  output logic [DATABITS-1:0]       cpu_dataout,
  output logic                      cpu_ready,
  output logic                      multihit,
  output logic [LINES-1:0]          line_fill,
  input  logic [LINES-1:0]          line_valid,
  input  logic [LINES-1:0]          line_miss,
  input  logic [LINES*DATABITS-1:0] line_out,
  input  logic [LINES*ADDRBITS-1:0] line_mem_addr,
  input  logic [LINES-1:0]          line_mem_rdreq,
  input  logic [LINES-1:0]          line_mem_wrreq,
  output logic [LINES-1:0]          line_mem_valid,
  output logic [ADDRBITS-1:0]       mem_addr,
  output logic                      mem_rdreq,
  output logic                      mem_wrreq,
  input  logic                      mem_valid
);

  state_e              state_q;
  logic [LINEIDX-1:0]  owner_q;
  logic                multihit_q;
  logic                cpu_ready_q;
  logic [DATABITS-1:0] cpu_dataout_q;
  logic [LINES-1:0]    line_fill_q;

  logic [LINEIDX-1:0]  hit_idx, victim_idx, touch_idx;
  logic [DATABITS-1:0] hit_data, own_data;
  logic                lookup_hit, fill_done, multi_valid, touch;

  assign hit_idx     = LINEIDX'(lowest_set(8'(line_valid)));
  assign lookup_hit  = (state_q == LOOKUP) && (|line_valid);
  assign fill_done   = (state_q == FILL) && line_valid[owner_q];
  assign multi_valid = (line_valid & (line_valid - LINES'(1))) != '0;

  always_comb begin
    hit_data = '0;
    own_data = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      if (hit_idx == i[LINEIDX-1:0]) hit_data = line_out[i*DATABITS +: DATABITS];
      if (owner_q == i[LINEIDX-1:0]) own_data = line_out[i*DATABITS +: DATABITS];
    end
  end

  // Memory port is decoded straight from state so reset drops the grant at once.
  always_comb begin
    mem_addr       = '0;
    mem_rdreq      = 1'b0;
    mem_wrreq      = 1'b0;
    line_mem_valid = '0;
    if (state_q == FILL) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        if (owner_q == i[LINEIDX-1:0]) begin
          mem_addr          = line_mem_addr[i*ADDRBITS +: ADDRBITS];
          mem_rdreq         = line_mem_rdreq[i];
          mem_wrreq         = line_mem_wrreq[i];
          line_mem_valid[i] = mem_valid;
        end
      end
    end
  end

`ifdef DCACHE_CTRL_PLRU_EN
  assign touch     = fill_done | lookup_hit;
  assign touch_idx = fill_done ? owner_q : hit_idx;
`else
  assign touch     = fill_done;
  assign touch_idx = owner_q;
`endif

  dcache_victim #(
    .LINES   (LINES),
    .LINEIDX (LINEIDX)
  ) u_victim (
    .clk        (clk),
    .reset      (reset),
    .touch      (touch),
    .touch_idx  (touch_idx),
    .victim_idx (victim_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      multihit_q    <= 1'b0;
      cpu_ready_q   <= 1'b0;
      cpu_dataout_q <= '0;
      line_fill_q   <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      line_fill_q <= '0;
      case (state_q)
        IDLE: begin
          if (cpu_rdreq || cpu_wrreq) state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (lookup_hit) begin
            cpu_dataout_q <= hit_data;
            cpu_ready_q   <= 1'b1;
            state_q       <= RESP;
            if (multi_valid) multihit_q <= 1'b1;
          end else if (&line_miss) begin
            owner_q     <= victim_idx;
            line_fill_q <= LINES'(1) << victim_idx;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (fill_done) begin
            cpu_dataout_q <= own_data;
            cpu_ready_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_dataout = cpu_dataout_q;
  assign line_fill   = line_fill_q;
  assign multihit    = multihit_q;

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Sequencer for LINES dcache_line instances, forming a small fully-associative data cache between the CPU core and the memory controller.
- Holds each CPU request open and waits one cycle for every line's registered hit/miss verdict.
- On a hit, returns that line's data.
- On an all-miss, picks a victim line, pulses its line_fill, and hands it the memory port until the victim reports valid.
- Owns the single memory-controller port; the lines never drive it directly.

Parameters:
LINES, 4, number of dcache_line instances (power of two, 2..8)
LINEIDX, 2, log2(LINES)
ADDRBITS, 32, address width
DATABITS, 32, data width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_rdreq  in  1  read request, held until cpu_ready
cpu_wrreq  in  1  write request, held until cpu_ready (address/data/be fan out directly to the lines)
cpu_dataout  out  DATABITS  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
multihit  out  1  sticky: more than one line_valid seen in the same cycle
line_fill  out  LINES  one-hot fill command, one-cycle pulse
line_valid  in  LINES  per-line hit/valid
line_miss  in  LINES  per-line miss
line_out  in  LINES*DATABITS  per-line read data, line i at [i*DATABITS +: DATABITS]
line_mem_addr  in  LINES*ADDRBITS  per-line memory address
line_mem_rdreq  in  LINES  per-line memory read request
line_mem_wrreq  in  LINES  per-line memory write request
line_mem_valid  out  LINES  mem_valid routed to the owning line only
mem_addr  out  ADDRBITS  memory-controller address
mem_rdreq  out  1  memory-controller read request
mem_wrreq  out  1  memory-controller write request
mem_valid  in  1  memory read data valid

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, owner=0, victim state=0, multihit=0.
  - All outputs 0: cpu_ready, cpu_dataout, line_fill, line_mem_valid, mem_addr, mem_rdreq, mem_wrreq.
  - Reset mid-FILL drops the memory grant the same instant; the lines are reset by the same net.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE: cpu_rdreq|cpu_wrreq -> LOOKUP.
- LOOKUP (lines present verdicts this cycle):
  - Any line_valid: hit index = lowest set bit; cpu_dataout <= line_out[hit]; -> RESP.
  - If popcount(line_valid)>1, set multihit (cleared only by reset).
  - Else if &line_miss: owner <= victim; line_fill[victim] pulses 1 cycle; -> FILL.
  - Else (neither verdict yet): stay in LOOKUP.
- FILL, combinational port mux:
  - mem_addr = line_mem_addr[owner]; mem_rdreq/mem_wrreq = owner's requests.
  - line_mem_valid = mem_valid << owner; all other lines see 0.
  - The owner performs its own flush and refill.
  - line_valid[owner]=1 -> cpu_dataout <= line_out[owner]; update victim state; -> RESP.
  - line_valid/line_miss from non-owner lines are ignored in FILL.
- RESP: cpu_ready=1 for exactly one cycle -> IDLE. The CPU drops or changes its request the cycle after cpu_ready.
- Latency:
  - Hit: request to cpu_ready = 3 cycles.
  - Miss: 3 cycles + fill duration.
- Outside FILL, the memory outputs are 0.

Optional Feature:
DCACHE_CTRL_PLRU_EN
- Defined: tree pseudo-LRU, LINES-1 bits.
  - Updated on every hit (LOOKUP->RESP) and every fill completion to point away from the touched line.
  - Victim = leaf reached by following the tree bits.
- Undefined: round-robin LINEIDX-bit pointer, incremented modulo LINES after each fill completion only; hits do not change it.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE=2'b00, LOOKUP=2'b01, FILL=2'b10, RESP=2'b11);
  - LINES, LINEIDX, ADDRBITS, DATABITS defaults;
  - a lowest-set-bit priority-encode function.
- Sub-module dcache_victim: replacement policy, both macro variants.
  - Inputs: touch, touch_idx.
  - Output: victim_idx.

Test Plan:
- Cold read, addr 0x0000_1000, all lines empty -> line_fill=4'b0001 pulse; mem port follows line 0; cpu_ready once when line_valid[0]; cpu_dataout = mem word 0x400.
- Re-read 0x0000_1004 -> hit on line 0; no line_fill; cpu_ready exactly 3 cycles after request.
- Misses to 0x1000, 0x2000, 0x3000, 0x4000, 0x5000 (round-robin) -> fills go to lines 0,1,2,3,0; the fifth fill's owner flushes, seen as mem_wrreq before mem_rdreq if the line is dirty.
- PLRU_EN: fill lines 0..3, hit line 0, then miss 0x6000 -> victim is line 2, not line 0.
- Force line_valid=4'b0110 in LOOKUP -> data from line 1, multihit=1 and sticky.
- Assert reset during FILL after 5 mem_valid beats -> line_fill, mem_rdreq, mem_wrreq, cpu_ready all 0 immediately; next request restarts from IDLE with victim 0.
